// File: rtl/rt_mem_pkg.sv
// Shared encodings for the data-memory access unit: operations, result
// flags and FSM states.
package rt_mem_pkg;

    typedef enum logic [1:0] {
        OP_RSVD0 = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD3 = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        FLAG_OK       = 2'b00,
        FLAG_MISALIGN = 2'b01,
        FLAG_RANGE    = 2'b10,
        FLAG_ILLEGAL  = 2'b11
    } mem_flag_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } mem_state_e;

endpackage

// File: rtl/rt_mem_addr_check.sv
// Request legality check; alignment/range checks exist only when
// MEM_ADDR_CHECK_EN is defined, otherwise only illegal ops are flagged.
module rt_mem_addr_check
    import rt_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic [1:0]  operation,
    input  logic [31:0] op1,
    output logic [1:0]  flag
);

    logic illegal;
    logic misalign;
    logic range_err;
    logic unused_op1;

    assign unused_op1 = ^op1;
    assign illegal    = (operation != OP_LOAD) && (operation != OP_STORE);

`ifdef MEM_ADDR_CHECK_EN
    assign misalign  = |op1[1:0];
    assign range_err = |op1[31:ADDR_WIDTH+2];
`else
    assign misalign  = 1'b0;
    assign range_err = 1'b0;
`endif

    // Illegal op outranks misalignment, which outranks range.
    always_comb begin
        flag = FLAG_OK;
        priority case (1'b1)
            illegal:   flag = FLAG_ILLEGAL;
            misalign:  flag = FLAG_MISALIGN;
            range_err: flag = FLAG_RANGE;
            default:   flag = FLAG_OK;
        endcase
    end

endmodule

// File: rtl/rt_mem_access_unit.sv
// Single-outstanding load/store unit in front of a synchronous data RAM.
// Address checks are enabled by defining MEM_ADDR_CHECK_EN.
module rt_mem_access_unit
    import rt_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            operation,
    input  logic [31:0]           op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic [1:0]            flag
);

    mem_state_e            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [1:0]            flag_q, flag_d;
    logic [1:0]            chk_flag;

    rt_mem_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_check (
        .operation (operation),
        .op1       (op1),
        .flag      (chk_flag)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        out_d   = out_q;
        flag_d  = flag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = operation;
                    addr_d = op1[ADDR_WIDTH+1:2];
                    data_d = op2;
                    out_d  = '0;
                    flag_d = chk_flag;
                    // Faulty requests skip the RAM entirely.
                    state_d = (chk_flag != FLAG_OK) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_WAIT;
            ST_WAIT: begin
                if (op_q == OP_LOAD) begin
                    out_d = ram_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            out_q   <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            out_q   <= out_d;
            flag_q  <= flag_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign ram_we     = (state_q == ST_ACCESS) && (op_q == OP_STORE);
    assign out        = out_q;
    assign flag       = flag_q;

endmodule

// File: tb/tb_rt_mem_access_unit.sv
// Directed bench for rt_mem_access_unit with a synchronous RAM model;
// error expectations follow MEM_ADDR_CHECK_EN.
module tb_rt_mem_access_unit;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    operation;
    logic [31:0]   op1;
    logic [DW-1:0] op2;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] out;
    logic [1:0]    flag;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    logic [31:0] we_addr;
    logic [31:0] we_data;

    rt_mem_access_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .operation  (operation),
        .op1        (op1),
        .op2        (op2),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_data   (ram_data),
        .ram_q      (ram_q),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out        (out),
        .flag       (flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_out,
                       input logic [1:0] exp_flag, input int exp_we);
        int lat;
        int wes;
        wes = 0;
        operation = op;
        op1 = a;
        op2 = d;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            if (ram_we) begin
                wes++;
                we_addr = 32'(ram_addr);
                we_data = ram_data;
            end
            step;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, out, exp_out);
        check({tag, "_flag"}, 32'(flag), 32'(exp_flag));
        check({tag, "_we"}, 32'(wes), 32'(exp_we));
        step;
        check({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        operation = 2'b00;
        op1 = '0;
        op2 = '0;
        resp_ready = 1'b1;
        we_addr = '0;
        we_data = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
        end
        mem[1] = 32'hDEADBEEF;
        step;
        step;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", ram_data, 32'd0);
        rst = 1'b0;
        step;

        run("load1", 2'b01, 32'h4, 32'h0, 3, 32'hDEADBEEF, 2'b00, 0);

        run("store8", 2'b10, 32'h8, 32'h12345678, 3, 32'h0, 2'b00, 1);
        check("store8_addr", we_addr, 32'd2);
        check("store8_data", we_data, 32'h12345678);
        check("store8_mem", mem[2], 32'h12345678);
        run("load8", 2'b01, 32'h8, 32'h0, 3, 32'h12345678, 2'b00, 0);

`ifdef MEM_ADDR_CHECK_EN
        run("mis6", 2'b01, 32'h6, 32'h0, 1, 32'h0, 2'b01, 0);
        run("oor800", 2'b01, 32'h800, 32'h0, 1, 32'h0, 2'b10, 0);
        run("misoor", 2'b01, 32'h806, 32'h0, 1, 32'h0, 2'b01, 0);
        run("st_mis", 2'b10, 32'hA, 32'h0BADF00D, 1, 32'h0, 2'b01, 0);
        run("st_oor", 2'b10, 32'h1000, 32'h0BADF00D, 1, 32'h0, 2'b10, 0);
`else
        run("mis6", 2'b01, 32'h6, 32'h0, 3, 32'hDEADBEEF, 2'b00, 0);
        run("oor800", 2'b01, 32'h800, 32'h0, 3, 32'h0, 2'b00, 0);
        run("misoor", 2'b01, 32'h806, 32'h0, 3, 32'hDEADBEEF, 2'b00, 0);
        run("st_mis", 2'b10, 32'hA, 32'h0BADF00D, 3, 32'h0, 2'b00, 1);
        check("st_mis_addr", we_addr, 32'd2);
        run("st_oor", 2'b10, 32'h1000, 32'h0BADF00D, 3, 32'h0, 2'b00, 1);
        check("st_oor_addr", we_addr, 32'd0);
`endif
        run("ill11", 2'b11, 32'h4, 32'h0, 1, 32'h0, 2'b11, 0);
        run("ill00", 2'b00, 32'h4, 32'h5, 1, 32'h0, 2'b11, 0);
        run("ill_prio", 2'b11, 32'h802, 32'h0, 1, 32'h0, 2'b11, 0);

        resp_ready = 1'b0;
        operation = 2'b01;
        op1 = 32'h4;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        step;
        step;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_out", out, 32'hDEADBEEF);
            check("bp_flag", 32'(flag), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
            step;
        end
        check("bp_hold", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        step;
        check("bp_release", {30'd0, resp_valid, req_ready}, 32'd1);

        operation = 2'b10;
        op1 = 32'hC;
        op2 = 32'hAAAA5555;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        check("rstmid_we_pre", 32'(ram_we), 32'd1);
        rst = 1'b1;
        step;
        check("rstmid_we", 32'(ram_we), 32'd0);
        check("rstmid_valid", 32'(resp_valid), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            check("rstmid_idle", {30'd0, ram_we, resp_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
